// File: rtl/table_fsm_pkg.sv
// rtl/table_fsm_pkg.sv - shared widths, constants and entry pack/unpack helpers for table_fsm_engine
package table_fsm_pkg;

    localparam int DEF_STATE_W  = 4;
    localparam int DEF_CTRL_W   = 3;
    localparam int DEF_RESULT_W = 16;
    localparam int DEF_STATUS_W = 4;
    localparam int DEF_CNT_W    = 16;

    localparam int STATE_IDLE   = 0;
    localparam logic [DEF_STATUS_W-1:0] MISS_STATUS = '1;

    // Helpers work on a wide carrier so any parameterisation up to 63 bits fits.
    localparam int ENTRY_MAX_W  = 64;

    function automatic logic [ENTRY_MAX_W-1:0] entry_field(
        input logic [ENTRY_MAX_W-1:0] entry,
        input int                     lsb,
        input int                     width
    );
        logic [ENTRY_MAX_W-1:0] mask;
        mask = (ENTRY_MAX_W'(1) << width) - ENTRY_MAX_W'(1);
        return (entry >> lsb) & mask;
    endfunction

    function automatic logic [ENTRY_MAX_W-1:0] pack_entry(
        input logic [ENTRY_MAX_W-1:0] next_state,
        input logic [ENTRY_MAX_W-1:0] result,
        input logic [ENTRY_MAX_W-1:0] status,
        input int                     result_w,
        input int                     status_w
    );
        return (next_state << (result_w + status_w)) | (result << status_w) | status;
    endfunction

    function automatic logic [ENTRY_MAX_W-1:0] entry_next_state(
        input logic [ENTRY_MAX_W-1:0] entry,
        input int                     state_w,
        input int                     result_w,
        input int                     status_w
    );
        return entry_field(entry, result_w + status_w, state_w);
    endfunction

    function automatic logic [ENTRY_MAX_W-1:0] entry_result(
        input logic [ENTRY_MAX_W-1:0] entry,
        input int                     result_w,
        input int                     status_w
    );
        return entry_field(entry, status_w, result_w);
    endfunction

    function automatic logic [ENTRY_MAX_W-1:0] entry_status(
        input logic [ENTRY_MAX_W-1:0] entry,
        input int                     status_w
    );
        return entry_field(entry, 0, status_w);
    endfunction

endpackage

// File: rtl/table_fsm_engine_if.sv
// rtl/table_fsm_engine_if.sv - control-word in / result out handshake bundle
interface table_fsm_engine_if
    import table_fsm_pkg::*;
#(
    parameter int STATE_W  = DEF_STATE_W,
    parameter int CTRL_W   = DEF_CTRL_W,
    parameter int RESULT_W = DEF_RESULT_W,
    parameter int STATUS_W = DEF_STATUS_W
);
    logic                in_valid;
    logic                in_ready;
    logic [CTRL_W-1:0]   in_control;
    logic                out_valid;
    logic                out_ready;
    logic [RESULT_W-1:0] out_result;
    logic [STATUS_W-1:0] out_status;
    logic [STATE_W-1:0]  out_state;
    logic                out_miss;

    modport master (
        output in_valid, in_control, out_ready,
        input  in_ready, out_valid, out_result, out_status, out_state, out_miss
    );

    modport slave (
        input  in_valid, in_control, out_ready,
        output in_ready, out_valid, out_result, out_status, out_state, out_miss
    );
endinterface

// File: rtl/table_fsm_mem.sv
// rtl/table_fsm_mem.sv - transition table storage with per-entry valid bits and combinational read
module table_fsm_mem
    import table_fsm_pkg::*;
#(
    parameter int ADDR_W  = DEF_STATE_W + DEF_CTRL_W,
    parameter int ENTRY_W = DEF_STATE_W + DEF_RESULT_W + DEF_STATUS_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [ADDR_W-1:0]  cfg_addr,
    input  logic [ENTRY_W-1:0] cfg_data,
    input  logic               cfg_inval,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               rd_hit
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]   valid_q;
    logic [DEPTH-1:0]   valid_d;

    // A write landing in the same cycle as an invalidate keeps its own entry valid.
    always_comb begin
        valid_d = valid_q;
        if (cfg_inval) begin
            valid_d = '0;
        end
        if (cfg_we) begin
            valid_d[cfg_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cfg_we) begin
            mem_q[cfg_addr] <= cfg_data;
        end
    end

    // Reads see registered contents only, so a same-cycle write never affects the lookup.
    assign rd_data = mem_q[rd_addr];
    assign rd_hit  = valid_q[rd_addr];

endmodule

// File: rtl/table_fsm_engine.sv
// rtl/table_fsm_engine.sv - table-driven Mealy engine: state register, result stage and step counter
module table_fsm_engine
    import table_fsm_pkg::*;
#(
    parameter int STATE_W  = DEF_STATE_W,
    parameter int CTRL_W   = DEF_CTRL_W,
    parameter int RESULT_W = DEF_RESULT_W,
    parameter int STATUS_W = DEF_STATUS_W,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  cfg_we,
    input  logic [STATE_W+CTRL_W-1:0]             cfg_addr,
    input  logic [STATE_W+RESULT_W+STATUS_W-1:0]  cfg_data,
    input  logic                                  cfg_inval,
    input  logic                                  soft_clear,
    table_fsm_engine_if.slave                     bus,
    output logic [CNT_W-1:0]                      step_count
);
    localparam int ADDR_W  = STATE_W + CTRL_W;
    localparam int ENTRY_W = STATE_W + RESULT_W + STATUS_W;

    logic [STATE_W-1:0]  state_q,      state_d;
    logic                out_valid_q,  out_valid_d;
    logic [RESULT_W-1:0] out_result_q, out_result_d;
    logic [STATUS_W-1:0] out_status_q, out_status_d;
    logic [STATE_W-1:0]  out_state_q,  out_state_d;
    logic                out_miss_q,   out_miss_d;
    logic [CNT_W-1:0]    step_count_q, step_count_d;

    logic                in_ready;
    logic                accept;
    logic [ADDR_W-1:0]   rd_addr;
    logic [ENTRY_W-1:0]  rd_data;
    logic                rd_hit;
    logic [ENTRY_MAX_W-1:0] rd_entry;
    logic [STATE_W-1:0]  hit_state;
    logic [RESULT_W-1:0] hit_result;
    logic [STATUS_W-1:0] hit_status;

    assign rd_addr    = {state_q, bus.in_control};
    assign rd_entry   = ENTRY_MAX_W'(rd_data);
    assign hit_state  = STATE_W'(entry_next_state(rd_entry, STATE_W, RESULT_W, STATUS_W));
    assign hit_result = RESULT_W'(entry_result(rd_entry, RESULT_W, STATUS_W));
    assign hit_status = STATUS_W'(entry_status(rd_entry, STATUS_W));

    table_fsm_mem #(
        .ADDR_W  (ADDR_W),
        .ENTRY_W (ENTRY_W)
    ) u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_inval (cfg_inval),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_hit    (rd_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= STATE_W'(STATE_IDLE);
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_status_q <= '0;
            out_state_q  <= '0;
            out_miss_q   <= 1'b0;
            step_count_q <= '0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_status_q <= out_status_d;
            out_state_q  <= out_state_d;
            out_miss_q   <= out_miss_d;
            step_count_q <= step_count_d;
        end
    end

    // soft_clear outranks everything; accept is already masked by in_ready below.
    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_status_d = out_status_q;
        out_state_d  = out_state_q;
        out_miss_d   = out_miss_q;
        step_count_d = step_count_q;
        if (soft_clear) begin
            state_d     = STATE_W'(STATE_IDLE);
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            if (step_count_q != '1) begin
                step_count_d = step_count_q + CNT_W'(1);
            end
            if (rd_hit) begin
                state_d      = hit_state;
                out_result_d = hit_result;
                out_status_d = hit_status;
                out_state_d  = hit_state;
                out_miss_d   = 1'b0;
            end else begin
                state_d      = STATE_W'(STATE_IDLE);
                out_result_d = '0;
                out_status_d = '1;
                out_state_d  = STATE_W'(STATE_IDLE);
                out_miss_d   = 1'b1;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        in_ready       = !soft_clear && (!out_valid_q || bus.out_ready);
        accept         = bus.in_valid && in_ready;
        bus.in_ready   = in_ready;
        bus.out_valid  = out_valid_q;
        bus.out_result = out_result_q;
        bus.out_status = out_status_q;
        bus.out_state  = out_state_q;
        bus.out_miss   = out_miss_q;
        step_count     = step_count_q;
    end

endmodule

// File: tb/tb_table_fsm_engine.sv
// tb/tb_table_fsm_engine.sv - directed self-checking bench for table_fsm_engine
module tb_table_fsm_engine;

    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic [6:0]  cfg_addr;
    logic [23:0] cfg_data;
    logic        cfg_inval;
    logic        soft_clear;
    logic [3:0]  step_count;

    int n_checks;
    int n_fail;

    table_fsm_engine_if bus ();

    table_fsm_engine #(
        .CNT_W (4)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_inval  (cfg_inval),
        .soft_clear (soft_clear),
        .bus        (bus.slave),
        .step_count (step_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [15:0] res, input logic [3:0] st,
                             input logic [3:0] nst, input logic miss, input logic [3:0] cnt);
        check_eq({tag, "_valid"},  32'(bus.out_valid),  32'd1);
        check_eq({tag, "_result"}, 32'(bus.out_result), 32'(res));
        check_eq({tag, "_status"}, 32'(bus.out_status), 32'(st));
        check_eq({tag, "_state"},  32'(bus.out_state),  32'(nst));
        check_eq({tag, "_miss"},   32'(bus.out_miss),   32'(miss));
        check_eq({tag, "_count"},  32'(step_count),     32'(cnt));
    endtask

    task automatic cfg_write(input logic [6:0] addr, input logic [23:0] data);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        @(posedge clk);
        #1;
        cfg_we   = 1'b0;
    endtask

    task automatic do_step(input logic [2:0] ctrl);
        int n;
        n = 0;
        bus.in_valid   = 1'b1;
        bus.in_control = ctrl;
        #1;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("step_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        cfg_we         = 1'b0;
        cfg_addr       = '0;
        cfg_data       = '0;
        cfg_inval      = 1'b0;
        soft_clear     = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_control = '0;
        bus.out_ready  = 1'b1;

        #12;
        check_eq("rst_valid",  32'(bus.out_valid),  32'd0);
        check_eq("rst_result", 32'(bus.out_result), 32'd0);
        check_eq("rst_status", 32'(bus.out_status), 32'd0);
        check_eq("rst_state",  32'(bus.out_state),  32'd0);
        check_eq("rst_miss",   32'(bus.out_miss),   32'd0);
        check_eq("rst_count",  32'(step_count),     32'd0);
        check_eq("rst_ready",  32'(bus.in_ready),   32'd1);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic hit from IDLE, then a miss from state 3.
        cfg_write({4'd0, 3'd0}, {4'd3, 16'h1111, 4'h1});
        check_eq("pre_accept_valid", 32'(bus.out_valid), 32'd0);
        do_step(3'd0);
        check_out("hit0", 16'h1111, 4'h1, 4'd3, 1'b0, 4'd1);
        do_step(3'd5);
        check_out("miss35", 16'h0000, 4'hF, 4'd0, 1'b1, 4'd2);

        // Back-pressure: result held, in_ready low, release accepts same cycle.
        cfg_write({4'd0, 3'd2}, {4'd7, 16'hABCD, 4'h2});
        cfg_write({4'd7, 3'd3}, {4'd1, 16'h7373, 4'h3});
        bus.out_ready = 1'b0;
        do_step(3'd2);
        check_out("stall_first", 16'hABCD, 4'h2, 4'd7, 1'b0, 4'd3);
        bus.in_valid   = 1'b1;
        bus.in_control = 3'd3;
        #1;
        for (int i = 0; i < 4; i++) begin
            check_eq("stall_ready",  32'(bus.in_ready),   32'd0);
            check_eq("stall_result", 32'(bus.out_result), 32'hABCD);
            check_eq("stall_valid",  32'(bus.out_valid),  32'd1);
            check_eq("stall_count",  32'(step_count),     32'd3);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        #1;
        check_eq("release_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check_out("release", 16'h7373, 4'h3, 4'd1, 1'b0, 4'd4);
        do_step(3'd0);
        check_out("miss10", 16'h0000, 4'hF, 4'd0, 1'b1, 4'd5);

        // Same-cycle write to the looked-up entry uses the old contents.
        cfg_write({4'd0, 3'd1}, {4'd2, 16'h0001, 4'h4});
        cfg_we   = 1'b1;
        cfg_addr = {4'd0, 3'd1};
        cfg_data = {4'd0, 16'h0002, 4'h5};
        do_step(3'd1);
        cfg_we   = 1'b0;
        check_out("wr_old", 16'h0001, 4'h4, 4'd2, 1'b0, 4'd6);
        do_step(3'd7);
        check_out("miss27", 16'h0000, 4'hF, 4'd0, 1'b1, 4'd7);
        do_step(3'd1);
        check_out("wr_new", 16'h0002, 4'h5, 4'd0, 1'b0, 4'd8);

        // soft_clear from state 7 with a pending result and a same-cycle request.
        do_step(3'd2);
        check_out("to7", 16'hABCD, 4'h2, 4'd7, 1'b0, 4'd9);
        soft_clear     = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_control = 3'd3;
        #1;
        check_eq("sc_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        soft_clear   = 1'b0;
        bus.in_valid = 1'b0;
        check_eq("sc_valid", 32'(bus.out_valid), 32'd0);
        check_eq("sc_count", 32'(step_count),    32'd9);
        do_step(3'd0);
        check_out("sc_idle", 16'h1111, 4'h1, 4'd3, 1'b0, 4'd10);

        // 20 back-to-back steps: counter saturates at 15.
        bus.in_valid   = 1'b1;
        bus.in_control = 3'd5;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check_eq("b2b_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid = 1'b0;
        check_eq("sat_count", 32'(step_count), 32'd15);
        check_eq("sat_miss",  32'(bus.out_miss), 32'd1);

        // Invalidate everything.
        cfg_inval = 1'b1;
        @(posedge clk);
        #1;
        cfg_inval = 1'b0;
        do_step(3'd0);
        check_out("inv0", 16'h0000, 4'hF, 4'd0, 1'b1, 4'd15);
        do_step(3'd2);
        check_out("inv2", 16'h0000, 4'hF, 4'd0, 1'b1, 4'd15);
        do_step(3'd1);
        check_out("inv1", 16'h0000, 4'hF, 4'd0, 1'b1, 4'd15);

        // Invalidate together with a write: the written entry survives.
        cfg_inval = 1'b1;
        cfg_write({4'd0, 3'd0}, {4'd0, 16'h5555, 4'h6});
        cfg_inval = 1'b0;
        do_step(3'd0);
        check_out("invwr_hit", 16'h5555, 4'h6, 4'd0, 1'b0, 4'd15);
        do_step(3'd2);
        check_out("invwr_miss", 16'h0000, 4'hF, 4'd0, 1'b1, 4'd15);

        // Asynchronous reset mid-operation.
        do_step(3'd0);
        check_out("pre_rst", 16'h5555, 4'h6, 4'd0, 1'b0, 4'd15);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid",  32'(bus.out_valid),  32'd0);
        check_eq("arst_result", 32'(bus.out_result), 32'd0);
        check_eq("arst_status", 32'(bus.out_status), 32'd0);
        check_eq("arst_miss",   32'(bus.out_miss),   32'd0);
        check_eq("arst_count",  32'(step_count),     32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_step(3'd0);
        check_out("post_rst", 16'h0000, 4'hF, 4'd0, 1'b1, 4'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/table_fsm_engine.md
# table_fsm_engine

Programmable, table-driven Mealy state machine with valid/ready handshakes: each accepted control word indexes a run-time-loaded table by {current state, control} and returns next state, result and status. It generalises the hard-coded case-statement state/output logic we use today to parametrised widths and a writable table. Software reprograms behaviour without RTL changes. It sits between a control-word producer and a result consumer; a config port loads the table.

## Interface
- STATE_W, 4, state register width; state 0 is IDLE
- CTRL_W, 3, control word width
- RESULT_W, 16, result width
- STATUS_W, 4, status width
- CNT_W, 16, step counter width
- Derived: DEPTH = 2^(STATE_W+CTRL_W); ENTRY_W = STATE_W+RESULT_W+STATUS_W, packed MSB→LSB {next_state, result, status}

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- cfg_we  in  1  table write strobe
- cfg_addr  in  STATE_W+CTRL_W  entry address {state, control}
- cfg_data  in  ENTRY_W  entry contents
- cfg_inval  in  1  single-cycle pulse; invalidates all entries
- soft_clear  in  1  synchronous return to IDLE, drops pending output
- in_valid / in_ready  in / out  1  control handshake
- in_control  in  CTRL_W  control word
- out_valid / out_ready  out / in  1  result handshake
- out_result  out  RESULT_W  result
- out_status  out  STATUS_W  status
- out_state  out  STATE_W  state after the step (registered)
- out_miss  out  1  step hit an unprogrammed entry
- step_count  out  CNT_W  accepted steps, saturating

## Operation
- Reset: state=0, all entry-valid bits=0, out_valid=0, out_result=0, out_status=0, out_state=0, out_miss=0, step_count=0. Table data RAM is not reset.
- in_ready = !out_valid || out_ready (combinational). A step is accepted when in_valid && in_ready.
- On accept: addr={state, in_control}.
  - Entry valid: state<=next_state; outputs load result/status/next_state; out_miss<=0.
  - Entry invalid: state<=0; out_result<=0; out_status<=all-ones; out_state<=0; out_miss<=1.
- out_valid<=1 on accept. It clears on out_valid && out_ready with no new accept.
- Outputs are stable while out_valid && !out_ready.
- Config writes:
  - cfg_we writes data and sets the valid bit at cfg_addr.
  - A write to the address being looked up in the same cycle has no effect on that lookup; the old entry (or invalid) is used.
  - cfg_inval clears all valid bits. If asserted with cfg_we in the same cycle, the write wins for its address.
- soft_clear:
  - Highest priority. State<=0 and out_valid<=0; any same-cycle accept is discarded.
  - in_ready is forced to 0 that cycle.
  - step_count is unchanged; table is unchanged.
- step_count increments per accept and saturates at 2^CNT_W−1.

## Timing
- Latency: result valid the cycle after accept (1 cycle). Throughput is 1 step/cycle with out_ready held high.
- Table read is combinational from the storage array, so there is no read bubble.
- Reset asserted mid-operation forces all outputs to their reset values asynchronously. Steps resume the first cycle after deassertion.
- Config writes are visible to lookups one cycle after the write cycle.

## Structure
- Package table_fsm_pkg:
  - default parameter values
  - IDLE state constant (0)
  - miss status encoding (all-ones)
  - functions to pack/unpack an entry given the widths
- Sub-module table_fsm_mem: DEPTH×ENTRY_W storage, valid-bit vector, write/invalidate logic, combinational read port with hit flag.
- Top holds the state register, the output register stage with handshake, and the counter.

## Test plan
- After reset, write entry {0,0}={3,16'h1111,4'h1}, send control 0 → out_result=16'h1111, out_status=4'h1, out_state=3, out_miss=0, one cycle after accept.
- Send control 5 from state 3 with no entry programmed → out_status=4'hF, out_result=0, out_state=0, out_miss=1, state back to IDLE.
- Hold out_ready=0 for 4 cycles with a valid result → in_ready=0, outputs unchanged. Then release: next step accepted the same cycle out_ready rises.
- In one cycle, cfg_we to {0,1} with new data while accepting control 1 in state 0 → output reflects the old entry; an identical later step reflects the new entry.
- soft_clear in the same cycle as in_valid, with state 7 → no output produced, state=0, step_count unchanged.
- CNT_W=4, 20 back-to-back steps → step_count saturates at 15. Then cfg_inval → every subsequent step gives out_miss=1.
